// File: rtl/imem_fetch_arbiter.sv
// Arbitrates core instruction fetches and program-loader word writes onto a single
// byte-wide instruction memory port; words are little-endian, four beats per access.
module imem_fetch_arbiter #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_valid,
   output logic              fetch_ready,
   input  logic [31:0]       fetch_addr,
   output logic              rsp_valid,
   output logic [31:0]       rsp_data,
   output logic              rsp_err,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [31:0]       ld_addr,
   input  logic [31:0]       ld_data,
   output logic              ld_done,
   output logic              ld_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   typedef enum logic [2:0] {StIdle, StRd, StRdWait, StWr, StErr} state_e;

   localparam logic [31:0] Nop = 32'h0000_0013;

   state_e      state_q;
   logic [1:0]  beat_q;
   logic        last_grant_q;  // 0 = fetch, 1 = loader
   logic [23:0] rbytes_q;
   logic [31:0] wdata_q;
   logic        mem_en_q;
   logic        mem_we_q;

   logic grant_fetch, grant_ld, fetch_acc, ld_acc, fetch_bad, ld_bad;

   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ((a >> ADDR_W) != 32'd0);
   endfunction

   always_comb begin
      grant_fetch = fetch_valid & (~ld_valid | last_grant_q);
      grant_ld    = ld_valid & (~fetch_valid | ~last_grant_q);
      fetch_ready = (state_q == StIdle) & ~reset & grant_fetch;
      ld_ready    = (state_q == StIdle) & ~reset & grant_ld;
      fetch_acc   = fetch_valid & fetch_ready;
      ld_acc      = ld_valid & ld_ready;
      fetch_bad   = addr_bad(fetch_addr);
      ld_bad      = addr_bad(ld_addr);
      // Gating by reset keeps an interrupted write from landing in the reset cycle.
      mem_en      = mem_en_q & ~reset;
      mem_we      = mem_we_q & ~reset;
      busy        = (state_q != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         beat_q       <= 2'd0;
         last_grant_q <= 1'b0;
         rbytes_q     <= 24'd0;
         wdata_q      <= 32'd0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= 8'd0;
         rsp_valid    <= 1'b0;
         rsp_err      <= 1'b0;
         rsp_data     <= 32'd0;
         ld_done      <= 1'b0;
         ld_err       <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         ld_done   <= 1'b0;
         ld_err    <= 1'b0;
         case (state_q)
            StIdle: begin
               if (fetch_acc) begin
                  last_grant_q <= 1'b0;
                  if (fetch_bad) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= Nop;
                     state_q   <= StErr;
                  end else begin
                     mem_en_q <= 1'b1;
                     mem_we_q <= 1'b0;
                     mem_addr <= fetch_addr[ADDR_W-1:0];
                     beat_q   <= 2'd0;
                     state_q  <= StRd;
                  end
               end else if (ld_acc) begin
                  last_grant_q <= 1'b1;
                  if (ld_bad) begin
                     ld_err  <= 1'b1;
                     state_q <= StErr;
                  end else begin
                     mem_en_q  <= 1'b1;
                     mem_we_q  <= 1'b1;
                     mem_addr  <= ld_addr[ADDR_W-1:0];
                     mem_wdata <= ld_data[7:0];
                     wdata_q   <= ld_data;
                     beat_q    <= 2'd0;
                     state_q   <= StWr;
                  end
               end
            end
            StRd: begin
               // Read data lags the address by one cycle; bytes shift in from the top.
               if (beat_q != 2'd0) rbytes_q <= {mem_rdata, rbytes_q[23:8]};
               if (beat_q == 2'd3) begin
                  mem_en_q <= 1'b0;
                  beat_q   <= 2'd0;
                  state_q  <= StRdWait;
               end else begin
                  beat_q   <= beat_q + 2'd1;
                  mem_addr <= mem_addr + ADDR_W'(1);
               end
            end
            StRdWait: begin
               rsp_valid <= 1'b1;
               rsp_data  <= {mem_rdata, rbytes_q};
               state_q   <= StIdle;
            end
            StWr: begin
               if (beat_q == 2'd3) begin
                  mem_en_q  <= 1'b0;
                  mem_we_q  <= 1'b0;
                  mem_wdata <= 8'd0;
                  ld_done   <= 1'b1;
                  beat_q    <= 2'd0;
                  state_q   <= StIdle;
               end else begin
                  beat_q    <= beat_q + 2'd1;
                  mem_addr  <= mem_addr + ADDR_W'(1);
                  mem_wdata <= wdata_q[15:8];
                  wdata_q   <= {8'd0, wdata_q[31:8]};
               end
            end
            StErr:   state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
